keypad_scan4: RTL and testbench
===============================

Name: keypad_scan4

Overview:
- Input-side counterpart of the 4-digit 7-segment display driver.
- Scans a 4x4 hex matrix keypad: drives one active-low column at a time and reads four active-low rows.
- Debounces the result and decodes a single key to a hex nibble.
- Shifts each accepted key into a 16-bit entry register that feeds the display's 16-bit number input directly.

Parameters:
- SCAN_DIV, 100000, clk100 cycles each column is held active (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; minimum 1.

Ports:
- clk100 input 1: 100 MHz system clock; all logic is on posedge.
- reset input 1: synchronous, active-high.
- col output 4: column drive, active-low one-hot; bit n low means column n is active.
- row input 4: row sense, active-low, externally pulled up; asynchronous to clk100.
- clear input 1: synchronous pulse; zeroes number.
- key_valid output 1: one-cycle pulse when a key press is accepted.
- key_code output 4: hex value of the last accepted key; held until the next press is accepted.
- key_held output 1: high from acceptance until the release is accepted.
- number output 16: entry register; the newest key occupies bits [3:0].

Behaviour:
- Reset values: col=4'b1110, key_valid=0, key_code=0, key_held=0, number=0. Column index, divider, scan accumulator and debounce counter all clear; state goes to IDLE.
- Row synchronizer: two flops on row, reset to 4'b1111. Every row decision uses the synchronized value.
- Divider: counts 0..SCAN_DIV-1 per column.
  - Rows are sampled on count SCAN_DIV-1, which allows settling time and covers synchronizer latency.
  - The column index then advances 0->1->2->3->0 and col updates on the next cycle.
- Scan accumulator: after the column-3 sample, one full-scan result is classified as exactly one of:
  - NONE: no rows low in any column.
  - SINGLE(code): exactly one row/column intersection low.
  - MULTI: two or more low; covers ghosting and chords.
  - The accumulator clears for the next scan.
- Key map (row r, column c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D.
- FSM, evaluated once per full-scan result:
  - IDLE:
    - SINGLE(k): candidate=k, cnt=1, go to PRESS_WAIT. If DEBOUNCE_SCANS=1, accept immediately.
    - NONE or MULTI: stay.
  - PRESS_WAIT:
    - SINGLE(same k): cnt++. When cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
    - SINGLE(different k): candidate=k, cnt=1.
    - NONE or MULTI: go to IDLE.
  - Accept actions, all in the same cycle:
    - key_valid=1 for exactly one cycle.
    - key_code=k.
    - key_held=1.
    - number = {number[11:0], k}; the oldest nibble is discarded.
  - HELD:
    - NONE: cnt=1, go to RELEASE_WAIT.
    - SINGLE (any code) or MULTI: stay. A new key is never accepted without a full release first.
  - RELEASE_WAIT:
    - NONE: cnt++. When cnt reaches DEBOUNCE_SCANS, set key_held=0 and go to IDLE.
    - SINGLE or MULTI: go back to HELD.
- clear: number=0 on the next cycle in any state.
  - If clear coincides with an accept, clear wins for number (number=0), but key_valid, key_code and key_held still update.
- Latency:
  - Row change to sampled: 2 cycles for the synchronizer, then at most one column slot.
  - Press to key_valid: at most (DEBOUNCE_SCANS+1) x 4 x SCAN_DIV + 3 cycles.
- Reset mid-scan or mid-debounce: all in-flight state is discarded; col returns to 4'b1110 and key_valid never fires spuriously.

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT).
  - Scan-class enum (NONE, SINGLE, MULTI).
  - Key-map constant or function (row, col -> nibble).
  - NUM_COLS=4 and NUM_ROWS=4.
- One sub-module, keypad_scan_core: divider, column drive, synchronizer and scan accumulator. It emits a one-cycle scan_done with class and code.
- The top module holds the debounce FSM and the number register.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, so one scan is 16 cycles):
- Reset, then idle with row=4'b1111 -> col cycles 1110,1101,1011,0111, each held 4 cycles; key_valid never asserts; number=16'h0000.
- Hold key r1/c2 (row[1] low while col[2] is low) for 4 scans -> exactly one key_valid pulse with key_code=4'h6, key_held=1, number=16'h0006.
- Press and release keys 1, A, 0, D, then press 7, each held and released for 4 scans -> number sequence 0001, 001A, 01A0, 1A0D, A0D7; the final value confirms the oldest nibble is dropped.
- Press r0/c0 and r0/c1 together for 4 scans -> MULTI; no key_valid, key_held=0. Release one key, leaving r0/c1 -> accepted as 4'h2 after 2 scans.
- Single-scan glitch on key 5, plus a held key with a 1-scan dropout -> no new key_valid for either; key_held stays 1 through the dropout.
- clear asserted in the same cycle as an accept of key 9 -> number=0000, key_valid=1, key_code=4'h9. Reset asserted mid PRESS_WAIT -> col=1110, no key_valid.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } fsm_state_e;

    // Classification of one complete four-column scan.
    typedef enum logic [1:0] {
        SC_NONE   = 2'd0,
        SC_SINGLE = 2'd1,
        SC_MULTI  = 2'd2
    } scan_class_e;

    // Hex value printed on the key at (row, col).
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keypad_scan4_if.sv
// Keypad pins plus the decoded-key outputs that feed the display driver.
interface keypad_scan4_if;
    import keypad_pkg::*;

    logic [NUM_COLS-1:0] col;        // active-low column drive
    logic [NUM_ROWS-1:0] row;        // active-low row sense, async
    logic                clear;      // zero the entry register
    logic                key_valid;  // one-cycle accept pulse
    logic [3:0]          key_code;   // last accepted key
    logic                key_held;   // key accepted and not yet released
    logic [15:0]         number;     // entry register, newest nibble low

    // Scanner side.
    modport master (
        output col, key_valid, key_code, key_held, number,
        input  row, clear
    );

    // Keypad hardware / consumer side.
    modport slave (
        input  col, key_valid, key_code, key_held, number,
        output row, clear
    );
endinterface

// File: rtl/keypad_scan_core.sv
// Column divider/drive, row synchronizer and per-scan accumulator.
// Emits a one-cycle scan_done_o with the class of each full scan.
module keypad_scan_core
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic                clk100,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row_i,
    output logic [NUM_COLS-1:0] col_o,
    output logic                scan_done_o,
    output scan_class_e         scan_class_o,
    output logic [3:0]          scan_code_o
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0]         div_q;
    logic [1:0]            col_idx_q;
    logic [NUM_COLS-1:0]   col_q;
    logic [NUM_ROWS-1:0]   row_meta_q, row_sync_q;
    logic [1:0]            acc_cnt_q, acc_cnt_d;   // saturates at 2 (= MULTI)
    logic [3:0]            acc_code_q, acc_code_d;
    logic                  scan_done_q;
    scan_class_e           scan_class_q;
    logic [3:0]            scan_code_q;

    logic                  sample;
    logic [NUM_ROWS-1:0]   row_low;
    logic [3:0]            row_code [NUM_ROWS];
    logic [2:0]            n_low;
    logic [3:0]            cur_code;
    logic [2:0]            sum_cnt;

    assign sample  = (div_q == DIV_LAST);
    assign row_low = ~row_sync_q;

    // Key code each row would produce in the currently active column.
    generate
        for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row_code
            assign row_code[gi] = key_map(2'(gi), col_idx_q);
        end
    endgenerate

    // Count low rows in this column and merge into the running scan result.
    always_comb begin
        n_low    = 3'd0;
        cur_code = 4'h0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (row_low[r]) begin
                n_low    = n_low + 3'd1;
                cur_code = row_code[r];
            end
        end
        sum_cnt    = {1'b0, acc_cnt_q} + n_low;
        acc_cnt_d  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        acc_code_d = (n_low != 3'd0) ? cur_code : acc_code_q;
    end

    // Divider, column rotation and two-flop row synchronizer.
    always_ff @(posedge clk100) begin
        if (reset) begin
            div_q      <= '0;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= row_i;
            row_sync_q <= row_meta_q;
            // Column drive follows the index one cycle later.
            col_q      <= ~(4'b0001 << col_idx_q);
            if (sample) begin
                div_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    // Accumulate per-column samples; classify after the column-3 sample.
    always_ff @(posedge clk100) begin
        if (reset) begin
            acc_cnt_q    <= 2'd0;
            acc_code_q   <= 4'h0;
            scan_done_q  <= 1'b0;
            scan_class_q <= SC_NONE;
            scan_code_q  <= 4'h0;
        end else begin
            scan_done_q <= 1'b0;
            if (sample) begin
                if (col_idx_q == 2'd3) begin
                    scan_done_q  <= 1'b1;
                    scan_code_q  <= acc_code_d;
                    case (acc_cnt_d)
                        2'd0:    scan_class_q <= SC_NONE;
                        2'd1:    scan_class_q <= SC_SINGLE;
                        default: scan_class_q <= SC_MULTI;
                    endcase
                    acc_cnt_q  <= 2'd0;
                    acc_code_q <= 4'h0;
                end else begin
                    acc_cnt_q  <= acc_cnt_d;
                    acc_code_q <= acc_code_d;
                end
            end
        end
    end

    assign col_o        = col_q;
    assign scan_done_o  = scan_done_q;
    assign scan_class_o = scan_class_q;
    assign scan_code_o  = scan_code_q;

endmodule

// File: rtl/keypad_scan4.sv
// 4x4 hex keypad scanner: debounce FSM and 16-bit entry register
// on top of the scan core.
module keypad_scan4
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic          clk100,
    input  logic          reset,
    keypad_scan4_if.master bus
);

    localparam logic [1:0] IDLE         = ST_IDLE;
    localparam logic [1:0] PRESS_WAIT   = ST_PRESS_WAIT;
    localparam logic [1:0] HELD         = ST_HELD;
    localparam logic [1:0] RELEASE_WAIT = ST_RELEASE_WAIT;

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DEB = CW'(DEBOUNCE_SCANS);

    logic        scan_done;
    scan_class_e scan_class;
    logic [3:0]  scan_code;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic          accept, release_key;
    logic          key_valid_q, key_held_q;
    logic [3:0]    key_code_q;
    logic [15:0]   number_q;

    keypad_scan_core #(.SCAN_DIV(SCAN_DIV)) u_core (
        .clk100       (clk100),
        .reset        (reset),
        .row_i        (bus.row),
        .col_o        (bus.col),
        .scan_done_o  (scan_done),
        .scan_class_o (scan_class),
        .scan_code_o  (scan_code)
    );

    // Debounce decisions, taken once per full-scan result.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        accept      = 1'b0;
        release_key = 1'b0;
        if (scan_done) begin
            case (state_q)
                IDLE: begin
                    if (scan_class == SC_SINGLE) begin
                        cand_d = scan_code;
                        cnt_d  = CW'(1);
                        if (DEB == CW'(1)) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = PRESS_WAIT;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (scan_class == SC_SINGLE) begin
                        if (scan_code == cand_q) begin
                            if (cnt_q + CW'(1) == DEB) begin
                                accept  = 1'b1;
                                state_d = HELD;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end else begin
                            cand_d = scan_code;
                            cnt_d  = CW'(1);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    // Anything other than an empty scan keeps the key held.
                    if (scan_class == SC_NONE) begin
                        cnt_d = CW'(1);
                        if (DEB == CW'(1)) begin
                            release_key = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            state_d = RELEASE_WAIT;
                        end
                    end
                end
                default: begin // RELEASE_WAIT
                    if (scan_class == SC_NONE) begin
                        if (cnt_q + CW'(1) == DEB) begin
                            release_key = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
            endcase
        end
    end

    // FSM state, key outputs and entry register; clear beats a same-cycle accept.
    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
            number_q    <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= scan_code;
                key_held_q <= 1'b1;
            end else if (release_key) begin
                key_held_q <= 1'b0;
            end
            if (bus.clear) begin
                number_q <= 16'h0000;
            end else if (accept) begin
                number_q <= {number_q[11:0], scan_code};
            end
        end
    end

    assign bus.key_valid = key_valid_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_held  = key_held_q;
    assign bus.number    = number_q;

endmodule

// File: tb/tb_keypad_scan4.sv
// Directed bench for keypad_scan4 with SCAN_DIV=4, DEBOUNCE_SCANS=2.
module tb_keypad_scan4;

    localparam int SCAN = 16;  // cycles per full scan

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] pressed = 16'h0000;  // bit r*4+c = key at row r, column c
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int vcnt = 0;
    int t_last = 0;
    logic [3:0] last_code = 4'h0;

    keypad_scan4_if bus();

    keypad_scan4 #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk100 (clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        logic [3:0] rv;
        rv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !bus.col[c]) rv[r] = 1'b0;
        bus.row = rv;
    end

    always @(negedge clk) begin
        if (!reset && bus.key_valid) begin
            vcnt      <= vcnt + 1;
            last_code <= bus.key_code;
            t_last    <= cyc;
        end
    end

    task automatic hold(input logic [15:0] mask, input int ncyc);
        pressed = mask;
        repeat (ncyc) @(negedge clk);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.clear = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.col !== 4'b1110) begin n_fail++; $display("FAIL reset_col got %b exp 1110", bus.col); end
        n_checks++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.key_valid); end
        n_checks++; if (bus.key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code got %h exp 0", bus.key_code); end
        n_checks++; if (bus.key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held got %b exp 0", bus.key_held); end
        n_checks++; if (bus.number !== 16'h0000) begin n_fail++; $display("FAIL reset_number got %h exp 0000", bus.number); end
        reset = 1'b0;
        $display("reset: col=%b number=%h", bus.col, bus.number);
    endtask

    task automatic test_idle_scan();
        logic [3:0] prev;
        int run;
        int changes;
        prev = bus.col;
        run = 1;
        changes = 0;
        for (int i = 0; i < 4 * SCAN; i++) begin
            @(negedge clk);
            if (bus.col !== prev) begin
                n_checks++;
                if (bus.col !== {prev[2:0], prev[3]}) begin
                    n_fail++; $display("FAIL idle_col_order got %b exp %b", bus.col, {prev[2:0], prev[3]});
                end
                if (changes > 0) begin
                    n_checks++;
                    if (run != 4) begin n_fail++; $display("FAIL idle_col_len got %0d exp 4", run); end
                end
                changes++;
                prev = bus.col;
                run = 1;
            end else begin
                run++;
            end
        end
        n_checks++; if (changes < 12) begin n_fail++; $display("FAIL idle_col_changes got %0d exp >=12", changes); end
        n_checks++; if (vcnt != 0) begin n_fail++; $display("FAIL idle_valid got %0d exp 0", vcnt); end
        n_checks++; if (bus.number !== 16'h0000) begin n_fail++; $display("FAIL idle_number got %h exp 0000", bus.number); end
        $display("idle scan: %0d column changes", changes);
    endtask

    task automatic test_single();
        int v0;
        bit seen;
        v0 = vcnt;
        seen = 0;
        pressed = 16'h0040;  // r1/c2 -> 6
        for (int i = 0; i < 4 * SCAN; i++) begin
            @(negedge clk);
            if (bus.key_valid && !seen) begin
                seen = 1;
                @(negedge clk);
                i++;
                n_checks++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width got %b exp 0", bus.key_valid); end
            end
        end
        n_checks++; if (vcnt - v0 != 1) begin n_fail++; $display("FAIL single_count got %0d exp 1", vcnt - v0); end
        n_checks++; if (bus.key_code !== 4'h6) begin n_fail++; $display("FAIL single_code got %h exp 6", bus.key_code); end
        n_checks++; if (bus.key_held !== 1'b1) begin n_fail++; $display("FAIL single_held got %b exp 1", bus.key_held); end
        n_checks++; if (bus.number !== 16'h0006) begin n_fail++; $display("FAIL single_number got %h exp 0006", bus.number); end
        hold(16'h0000, 4 * SCAN);
        n_checks++; if (bus.key_held !== 1'b0) begin n_fail++; $display("FAIL single_release got %b exp 0", bus.key_held); end
        $display("single key: code=%h number=%h", bus.key_code, bus.number);
    endtask

    task automatic test_sequence();
        logic [15:0] masks [5];
        logic [15:0] exp_num [5];
        masks   = '{16'h0001, 16'h0008, 16'h2000, 16'h8000, 16'h0100};
        exp_num = '{16'h0001, 16'h001A, 16'h01A0, 16'h1A0D, 16'hA0D7};
        pulse_clear();
        n_checks++; if (bus.number !== 16'h0000) begin n_fail++; $display("FAIL seq_clear got %h exp 0000", bus.number); end
        for (int k = 0; k < 5; k++) begin
            hold(masks[k], 4 * SCAN);
            n_checks++;
            if (bus.number !== exp_num[k]) begin n_fail++; $display("FAIL seq_number[%0d] got %h exp %h", k, bus.number, exp_num[k]); end
            $display("sequence key %0d: number=%h", k, bus.number);
            hold(16'h0000, 4 * SCAN);
        end
    endtask

    task automatic test_multi();
        int v0;
        v0 = vcnt;
        hold(16'h0003, 4 * SCAN);  // keys 1 and 2 together
        n_checks++; if (vcnt != v0) begin n_fail++; $display("FAIL multi_valid got %0d exp %0d", vcnt, v0); end
        n_checks++; if (bus.key_held !== 1'b0) begin n_fail++; $display("FAIL multi_held got %b exp 0", bus.key_held); end
        hold(16'h0002, 4 * SCAN);  // release key 1, key 2 remains
        n_checks++; if (vcnt - v0 != 1) begin n_fail++; $display("FAIL multi_after_count got %0d exp 1", vcnt - v0); end
        n_checks++; if (bus.key_code !== 4'h2) begin n_fail++; $display("FAIL multi_after_code got %h exp 2", bus.key_code); end
        n_checks++; if (bus.number !== 16'h0D72) begin n_fail++; $display("FAIL multi_after_number got %h exp 0d72", bus.number); end
        $display("multi then single: code=%h number=%h", bus.key_code, bus.number);
        hold(16'h0000, 4 * SCAN);
    endtask

    task automatic test_glitch_dropout();
        int v0;
        bit held_dropped;
        v0 = vcnt;
        hold(16'h0020, SCAN);  // key 5 for exactly one scan
        hold(16'h0000, 4 * SCAN);
        n_checks++; if (vcnt != v0) begin n_fail++; $display("FAIL glitch_valid got %0d exp %0d", vcnt, v0); end
        hold(16'h0200, 4 * SCAN);  // key 8 properly pressed
        n_checks++; if (vcnt - v0 != 1) begin n_fail++; $display("FAIL dropout_accept got %0d exp 1", vcnt - v0); end
        held_dropped = 0;
        pressed = 16'h0000;
        for (int i = 0; i < SCAN; i++) begin @(negedge clk); if (!bus.key_held) held_dropped = 1; end
        pressed = 16'h0200;
        for (int i = 0; i < 4 * SCAN; i++) begin @(negedge clk); if (!bus.key_held) held_dropped = 1; end
        n_checks++; if (held_dropped) begin n_fail++; $display("FAIL dropout_held got 0 exp 1"); end
        n_checks++; if (vcnt - v0 != 1) begin n_fail++; $display("FAIL dropout_count got %0d exp 1", vcnt - v0); end
        n_checks++; if (bus.number !== 16'hD728) begin n_fail++; $display("FAIL dropout_number got %h exp d728", bus.number); end
        $display("glitch/dropout: number=%h held=%b", bus.number, bus.key_held);
        hold(16'h0000, 4 * SCAN);
        n_checks++; if (bus.key_held !== 1'b0) begin n_fail++; $display("FAIL dropout_release got %b exp 0", bus.key_held); end
    endtask

    task automatic test_clear_accept();
        bit got;
        got = 0;
        pressed = 16'h0400;  // key 9
        for (int i = 0; i < 10 * SCAN && !got; i++) begin
            @(negedge clk);
            if (bus.key_valid) begin
                got = 1;
                bus.clear = 1'b0;
                n_checks++; if (bus.number !== 16'h0000) begin n_fail++; $display("FAIL clr_acc_number got %h exp 0000", bus.number); end
                n_checks++; if (bus.key_code !== 4'h9) begin n_fail++; $display("FAIL clr_acc_code got %h exp 9", bus.key_code); end
                n_checks++; if (bus.key_held !== 1'b1) begin n_fail++; $display("FAIL clr_acc_held got %b exp 1", bus.key_held); end
            end else begin
                // Pulse clear in the cycle of every scan result so one lands on the accept.
                bus.clear = ((cyc + 1 - t_last) % SCAN == 0);
            end
        end
        bus.clear = 1'b0;
        n_checks++; if (!got) begin n_fail++; $display("FAIL clr_acc_timeout got no key_valid exp pulse"); end
        $display("clear with accept: number=%h code=%h", bus.number, bus.key_code);
        hold(16'h0000, 4 * SCAN);
    endtask

    task automatic test_reset_mid();
        int v0;
        bit aligned;
        aligned = 0;
        for (int i = 0; i < SCAN && !aligned; i++) begin
            @(negedge clk);
            if ((cyc - t_last) % SCAN == 0) aligned = 1;
        end
        v0 = vcnt;
        hold(16'h0004, 24);  // key 3: one SINGLE scan seen, accept still pending
        n_checks++; if (vcnt != v0) begin n_fail++; $display("FAIL midrst_early got %0d exp %0d", vcnt, v0); end
        reset = 1'b1;
        pressed = 16'h0000;
        @(negedge clk);
        n_checks++; if (bus.col !== 4'b1110) begin n_fail++; $display("FAIL midrst_col got %b exp 1110", bus.col); end
        n_checks++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", bus.key_valid); end
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (bus.number !== 16'h0000) begin n_fail++; $display("FAIL midrst_number got %h exp 0000", bus.number); end
        repeat (4 * SCAN) @(negedge clk);
        n_checks++; if (vcnt != v0) begin n_fail++; $display("FAIL midrst_spurious got %0d exp %0d", vcnt, v0); end
        n_checks++; if (bus.key_held !== 1'b0) begin n_fail++; $display("FAIL midrst_held got %b exp 0", bus.key_held); end
        $display("reset mid press: col=%b valid_count=%0d", bus.col, vcnt);
    endtask

    initial begin
        bus.clear = 1'b0;
        test_reset();
        test_idle_scan();
        test_single();
        test_sequence();
        test_multi();
        test_glitch_dropout();
        test_clear_accept();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
